// File: rtl/cc_pkg.sv
// Shared definitions for the rate-1/N convolutional encoder with error injection:
// FSM states, parameter limits, default generator polynomials and the tap parity helper.
// Package only: no latency or backpressure of its own.
package cc_pkg;

    localparam int CC_K_MAX   = 9;
    localparam int CC_N_MAX   = 4;
    localparam int CC_GPOLY_W = 9;
    localparam int CC_CH_W    = 2;
    localparam int CC_CNT_W   = 8;

    // G[0] = 7 (octal), G[1] = 5 (octal): the classic K=3 rate-1/2 code
    localparam logic [CC_GPOLY_W-1:0] CC_G0_DEFAULT = 9'o007;
    localparam logic [CC_GPOLY_W-1:0] CC_G1_DEFAULT = 9'o005;
    localparam logic [2*CC_GPOLY_W-1:0] CC_G_DEFAULT = {CC_G1_DEFAULT, CC_G0_DEFAULT};

    typedef enum logic [1:0] {
        CC_IDLE  = 2'd0,
        CC_DATA  = 2'd1,
        CC_FLUSH = 2'd2
    } cc_state_e;

    function automatic logic cc_parity(input logic [CC_K_MAX-1:0] taps,
                                       input logic [CC_K_MAX-1:0] window);
        return ^(taps & window);
    endfunction

endpackage

// File: rtl/cc_noise_inj.sv
// Periodic single-bit error injector: counts loaded symbols, flips one channel every NOISE_PERIOD.
// Latency: flip mask is combinational on the load cycle; counters update on the load edge.
// Backpressure: none; advances only when the encoder loads a symbol.
module cc_noise_inj
    import cc_pkg::*;
#(
    parameter int N            = 2,
    parameter int NOISE_PERIOD = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         noise_en,
    output logic [N-1:0] flip_mask,
    output logic         inject
);

    logic [CC_CNT_W-1:0] sym_cnt;
    logic [CC_CH_W-1:0]  ch;
    logic                wrap;

    assign wrap      = (sym_cnt == CC_CNT_W'(NOISE_PERIOD - 1));
    assign inject    = load && noise_en && wrap;
    assign flip_mask = inject ? (N'(1) << ch) : '0;

    // sym_cnt counts every loaded symbol; ch only moves when a flip is actually applied
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sym_cnt <= '0;
            ch      <= '0;
        end else begin
            if (load) begin
                sym_cnt <= wrap ? '0 : sym_cnt + 1'b1;
            end
            if (inject) begin
                ch <= (ch == CC_CH_W'(N - 1)) ? '0 : ch + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_encoder_noisy.sv
// Rate-1/N convolutional encoder with K-1 zero tail per frame and periodic error injection.
// Latency: one cycle from accepted bit (or tail step) to registered symbol on out_bits.
// Backpressure: single output register; in_ready/tail steps only when it is empty or draining.
module conv_encoder_noisy
    import cc_pkg::*;
#(
    parameter int                      K            = 3,
    parameter int                      N            = 2,
    parameter logic [N*CC_GPOLY_W-1:0] G            = CC_G_DEFAULT,
    parameter int                      NOISE_PERIOD = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         in_bit,
    input  logic         in_last,
    output logic         in_ready,
    input  logic         noise_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_bits,
    output logic         out_last,
    output logic         out_err
);

    localparam int SRW = K - 1;
    localparam int TCW = 4;

    cc_state_e      state_q;
    cc_state_e      state_d;
    logic [SRW-1:0] sr_q;
    logic [TCW-1:0] tail_q;

    logic [N-1:0]   out_bits_q;
    logic           out_last_q;
    logic           out_err_q;
    logic           out_valid_q;

    logic           out_free;
    logic           in_ready_int;
    logic           accept;
    logic           tail_load;
    logic           tail_final;
    logic           load;
    logic           enc_bit;
    logic [K-1:0]   window;
    logic [N-1:0]   clean;
    logic [N-1:0]   flip_mask;
    logic           inject;

    assign out_free     = !out_valid_q || out_ready;
    assign in_ready_int = !reset && (state_q != CC_FLUSH) && out_free;
    assign accept       = in_valid && in_ready_int;
    assign tail_load    = (state_q == CC_FLUSH) && out_free;
    assign tail_final   = tail_load && (tail_q == TCW'(K - 2));
    assign load         = accept || tail_load;

    // Tail steps feed zeros; window[0] is the bit being encoded, window[j] the j-th previous bit
    assign enc_bit = (state_q == CC_FLUSH) ? 1'b0 : in_bit;
    assign window  = {sr_q, enc_bit};

    always_comb begin
        clean = '0;
        for (int i = 0; i < N; i++) begin
            clean[i] = ^(G[i*CC_GPOLY_W +: K] & window);
        end
    end

    cc_noise_inj #(
        .N            (N),
        .NOISE_PERIOD (NOISE_PERIOD)
    ) u_noise (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .noise_en  (noise_en),
        .flip_mask (flip_mask),
        .inject    (inject)
    );

    // A bit accepted in IDLE with in_last is a one-bit frame and goes straight to the tail
    always_comb begin
        state_d = state_q;
        case (state_q)
            CC_IDLE: begin
                if (accept) begin
                    state_d = in_last ? CC_FLUSH : CC_DATA;
                end
            end
            CC_DATA: begin
                if (accept && in_last) begin
                    state_d = CC_FLUSH;
                end
            end
            CC_FLUSH: begin
                if (tail_final) begin
                    state_d = CC_IDLE;
                end
            end
            default: state_d = CC_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= CC_IDLE;
            sr_q    <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            if (tail_final) begin
                sr_q   <= '0;
                tail_q <= '0;
            end else begin
                if (load) begin
                    sr_q <= window[SRW-1:0];
                end
                if (tail_load) begin
                    tail_q <= tail_q + 1'b1;
                end
            end
        end
    end

    // Output register holds its contents until drained, so a stall never alters a symbol
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_bits_q  <= clean ^ flip_mask;
            out_last_q  <= tail_final;
            out_err_q   <= inject;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready  = in_ready_int;
    assign out_valid = out_valid_q;
    assign out_bits  = out_bits_q;
    assign out_last  = out_last_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_conv_encoder_noisy.sv
// Bench for conv_encoder_noisy: three configurations behind a select mux, checked
// against a convolution-sum reference with a global symbol counter for error injection.
module tb_conv_encoder_noisy;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset     = 1'b1;
    logic in_valid  = 1'b0;
    logic in_bit    = 1'b0;
    logic in_last   = 1'b0;
    logic out_ready = 1'b0;
    logic noise_en  = 1'b0;
    int   sel       = 0;

    logic iv_a, iv_b, iv_c;
    assign iv_a = in_valid && (sel == 0);
    assign iv_b = in_valid && (sel == 1);
    assign iv_c = in_valid && (sel == 2);

    logic       ir_a, ov_a, ol_a, oe_a;
    logic [1:0] ob_a;
    logic       ir_b, ov_b, ol_b, oe_b;
    logic [1:0] ob_b;
    logic       ir_c, ov_c, ol_c, oe_c;
    logic [2:0] ob_c;

    conv_encoder_noisy #(.K(3), .N(2), .G({9'o005, 9'o007}), .NOISE_PERIOD(4)) dut_a (
        .clock(clock), .reset(reset), .in_valid(iv_a), .in_bit(in_bit), .in_last(in_last),
        .in_ready(ir_a), .noise_en(noise_en), .out_valid(ov_a), .out_ready(out_ready),
        .out_bits(ob_a), .out_last(ol_a), .out_err(oe_a));

    conv_encoder_noisy #(.K(5), .N(2), .G({9'o023, 9'o035}), .NOISE_PERIOD(8)) dut_b (
        .clock(clock), .reset(reset), .in_valid(iv_b), .in_bit(in_bit), .in_last(in_last),
        .in_ready(ir_b), .noise_en(noise_en), .out_valid(ov_b), .out_ready(out_ready),
        .out_bits(ob_b), .out_last(ol_b), .out_err(oe_b));

    conv_encoder_noisy #(.K(7), .N(3), .G({9'o133, 9'o171, 9'o165}), .NOISE_PERIOD(8)) dut_c (
        .clock(clock), .reset(reset), .in_valid(iv_c), .in_bit(in_bit), .in_last(in_last),
        .in_ready(ir_c), .noise_en(noise_en), .out_valid(ov_c), .out_ready(out_ready),
        .out_bits(ob_c), .out_last(ol_c), .out_err(oe_c));

    logic       ir_m, ov_m, ol_m, oe_m;
    logic [3:0] ob_m;
    always_comb begin
        ir_m = ir_a; ov_m = ov_a; ol_m = ol_a; oe_m = oe_a; ob_m = {2'b00, ob_a};
        case (sel)
            1: begin ir_m = ir_b; ov_m = ov_b; ol_m = ol_b; oe_m = oe_b; ob_m = {2'b00, ob_b}; end
            2: begin ir_m = ir_c; ov_m = ov_c; ol_m = ol_c; oe_m = oe_c; ob_m = {1'b0, ob_c}; end
            default: ;
        endcase
    end

    int         vectors     = 0;
    int         miscompares = 0;
    int         sym_total[3];
    int         inj_cnt[3];
    bit         frame_bits[0:127];
    logic [5:0] got_q[$];
    int         last_flush_samples;

    function automatic int k_of(int s);
        return (s == 0) ? 3 : (s == 1) ? 5 : 7;
    endfunction
    function automatic int n_of(int s);
        return (s == 2) ? 3 : 2;
    endfunction
    function automatic int np_of(int s);
        return (s == 0) ? 4 : 8;
    endfunction
    function automatic logic [8:0] gen_of(int s, int i);
        case (s)
            0:       return (i == 0) ? 9'o007 : 9'o005;
            1:       return (i == 0) ? 9'o035 : 9'o023;
            default: return (i == 0) ? 9'o165 : (i == 1) ? 9'o171 : 9'o133;
        endcase
    endfunction

    // Symbol n of a frame: sum over taps of g[j]*u[n-j] mod 2, u = data then K-1 zeros
    function automatic logic [3:0] clean_sym(int s, int nbits, int n);
        logic [3:0] r = '0;
        logic [8:0] g;
        for (int i = 0; i < n_of(s); i++) begin
            g = gen_of(s, i);
            for (int j = 0; j < k_of(s); j++) begin
                if (g[j] && (n - j >= 0) && (n - j < nbits)) r[i] = r[i] ^ frame_bits[n - j];
            end
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int s = 0; s < 3; s++) begin
            sym_total[s] = 0;
            inj_cnt[s]   = 0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        clear_model();
    endtask

    // mode 0: out_ready=1, 1: toggle 1,0,1,0..., 2: random
    task automatic drive_frame(input int nbits, input int mode, input bit noise);
        int         k     = k_of(sel);
        int         total = nbits + k - 1;
        int         idx = 0, cyc = 0, first_acc = -1, last_acc = -1, first_vld = -1;
        int         flush_samples = 0, flush_viol = 0;
        bit         prev_stall = 0, last_vis, acc_in, acc_out;
        logic [5:0] prev_val = '0, exp;
        logic [3:0] eb;
        int         s;
        got_q.delete();
        noise_en = noise;
        while (got_q.size() < total && cyc < 3000) begin
            @(negedge clock);
            if (prev_stall) begin
                vectors++;
                if (ov_m !== 1'b1 || {ol_m, oe_m, ob_m} !== prev_val) begin
                    miscompares++;
                    $display("FAIL stall_hold sel=%0d cyc=%0d got v=%b %b want v=1 %b", sel, cyc, ov_m, {ol_m, oe_m, ob_m}, prev_val);
                end
            end
            if (ov_m === 1'b1 && first_vld < 0) first_vld = cyc;
            last_vis  = (ov_m === 1'b1) && (ol_m === 1'b1);
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 3) != 0);
            if (idx < nbits) begin
                in_valid = 1'b1;
                in_bit   = frame_bits[idx];
                in_last  = (idx == nbits - 1);
            end else begin
                in_valid = !last_vis;
                in_bit   = 1'($urandom);
                in_last  = 1'b0;
            end
            #1;
            acc_in  = in_valid && (ir_m === 1'b1);
            acc_out = (ov_m === 1'b1) && out_ready;
            if (idx >= nbits && !last_vis) begin
                flush_samples++;
                if (ir_m !== 1'b0) flush_viol++;
            end
            if (acc_in) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                idx++;
            end
            if (acc_out) got_q.push_back({ol_m, oe_m, ob_m});
            prev_stall = (ov_m === 1'b1) && !out_ready;
            prev_val   = {ol_m, oe_m, ob_m};
            @(posedge clock);
            cyc++;
        end
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        last_flush_samples = flush_samples;

        vectors++;
        if (got_q.size() != total) begin
            miscompares++;
            $display("FAIL symbol_count sel=%0d got %0d want %0d (cycles %0d)", sel, got_q.size(), total, cyc);
        end
        for (int n = 0; n < got_q.size(); n++) begin
            eb = clean_sym(sel, nbits, n);
            s  = ++sym_total[sel];
            exp = {(n == total - 1), 1'b0, eb};
            if (noise && (s % np_of(sel) == 0)) begin
                eb[inj_cnt[sel] % n_of(sel)] = ~eb[inj_cnt[sel] % n_of(sel)];
                exp = {(n == total - 1), 1'b1, eb};
                inj_cnt[sel]++;
            end
            vectors++;
            if (got_q[n] !== exp) begin
                miscompares++;
                $display("FAIL symbol sel=%0d n=%0d got last/err/bits=%b want %b", sel, n, got_q[n], exp);
            end
        end
        vectors++;
        if (first_vld != first_acc + 1) begin
            miscompares++;
            $display("FAIL latency sel=%0d first valid cyc %0d want %0d", sel, first_vld, first_acc + 1);
        end
        if (mode == 0) begin
            vectors++;
            if (last_acc - first_acc != nbits - 1) begin
                miscompares++;
                $display("FAIL throughput sel=%0d span %0d want %0d", sel, last_acc - first_acc, nbits - 1);
            end
        end
        vectors++;
        if (flush_viol != 0) begin
            miscompares++;
            $display("FAIL flush_ready sel=%0d in_ready high %0d cycles want 0", sel, flush_viol);
        end
    endtask

    task automatic check_pairs(input string name, input logic [1:0] want [6]);
        for (int n = 0; n < 6 && n < got_q.size(); n++) begin
            vectors++;
            if (got_q[n][1:0] !== want[n] || got_q[n][5] !== (n == 5)) begin
                miscompares++;
                $display("FAIL %s n=%0d got bits=%b last=%b want bits=%b last=%b", name, n, got_q[n][1:0], got_q[n][5], want[n], (n == 5));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            vectors++;
            if ({ov_m, ol_m, oe_m, ir_m, ob_m} !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_state sel=%0d got v/l/e/rdy/bits=%b want 00000000", s, {ov_m, ol_m, oe_m, ir_m, ob_m});
            end
        end
        sel = 0;
        @(negedge clock);
        reset = 1'b0;
        clear_model();
        @(posedge clock);
        #1;
        vectors++;
        if (ir_m !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset got %b want 1", ir_m);
        end
    endtask

    task automatic test_basic();
        logic [1:0] want [6] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
        sel = 0;
        frame_bits[0] = 1; frame_bits[1] = 0; frame_bits[2] = 1; frame_bits[3] = 1;
        drive_frame(4, 0, 1'b0);
        check_pairs("basic_seq", want);
    endtask

    task automatic test_stall();
        logic [1:0] want [6] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
        sel = 0;
        frame_bits[0] = 1; frame_bits[1] = 0; frame_bits[2] = 1; frame_bits[3] = 1;
        drive_frame(4, 1, 1'b0);
        check_pairs("stall_seq", want);
    endtask

    task automatic test_noise();
        logic [1:0] wb;
        apply_reset();
        sel = 0;
        for (int i = 0; i < 12; i++) frame_bits[i] = 0;
        drive_frame(12, 0, 1'b1);
        for (int n = 0; n < 14 && n < got_q.size(); n++) begin
            wb = (n == 3 || n == 11) ? 2'b01 : (n == 7) ? 2'b10 : 2'b00;
            vectors++;
            if (got_q[n][1:0] !== wb || got_q[n][4] !== (n == 3 || n == 7 || n == 11)) begin
                miscompares++;
                $display("FAIL noise_pattern n=%0d got bits=%b err=%b want bits=%b err=%b", n, got_q[n][1:0], got_q[n][4], wb, (n == 3 || n == 7 || n == 11));
            end
        end
        noise_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acc = 0, cyc = 0;
        apply_reset();
        sel = 0;
        out_ready = 1'b1;
        while (acc < 2 && cyc < 50) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_bit   = 1'b1;
            in_last  = 1'b0;
            #1;
            if (ir_m === 1'b1) acc++;
            @(posedge clock);
            cyc++;
        end
        @(negedge clock);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (ov_m !== 1'b0 || ir_m !== 1'b0 || acc != 2) begin
            miscompares++;
            $display("FAIL reset_mid got valid=%b ready=%b accepted=%0d want 0 0 2", ov_m, ir_m, acc);
        end
        @(negedge clock);
        reset = 1'b0;
        clear_model();
        @(posedge clock);
        #1;
        vectors++;
        if (ir_m !== 1'b1 || ov_m !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_recover got ready=%b valid=%b want 1 0", ir_m, ov_m);
        end
        frame_bits[0] = 1;
        frame_bits[1] = 1'($urandom);
        frame_bits[2] = 1'($urandom);
        drive_frame(3, 2, 1'b0);
        vectors++;
        if (got_q.size() == 0 || got_q[0][1:0] !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_mid_first got %b want 11", (got_q.size() > 0) ? got_q[0][1:0] : 2'bxx);
        end
    endtask

    task automatic test_single_bit();
        sel = 1;
        frame_bits[0] = 1;
        drive_frame(1, 0, 1'b0);
        vectors++;
        if (last_flush_samples != 4) begin
            miscompares++;
            $display("FAIL single_bit_flush got %0d tail cycles want 4", last_flush_samples);
        end
    endtask

    task automatic test_k7_random();
        sel = 2;
        for (int i = 0; i < 64; i++) frame_bits[i] = 1'($urandom);
        drive_frame(64, 2, 1'b0);
        for (int i = 0; i < 40; i++) frame_bits[i] = 1'($urandom);
        drive_frame(40, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        sel = 0;
        for (int f = 0; f < 3; f++) begin
            int nb = $urandom_range(1, 20);
            for (int i = 0; i < nb; i++) frame_bits[i] = 1'($urandom);
            drive_frame(nb, f % 3, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_noise();
        test_reset_mid();
        test_single_bit();
        test_k7_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_encoder_noisy.md
CONV_ENCODER_NOISY -- requirements
Module: conv_encoder_noisy

Interface
REQ-001 SHALL have parameter K, default 3: constraint length, legal range 3..9.
REQ-002 SHALL have parameter N, default 2: code outputs per input bit (rate 1/N), legal range 2..4.
REQ-003 SHALL have parameter G, default {9'o005, 9'o007}: N packed 9-bit generator polynomials; G[i] drives out_bits[i]; bit 0 taps in_bit, bit j taps the j-th previous bit; only bits K-1..0 are used.
REQ-004 SHALL have parameter NOISE_PERIOD, default 8: symbol spacing between injected errors, legal range 2..255.
REQ-005 SHALL have the following ports:
clock  input  1  sole clock, rising edge; reset is asynchronous and active-high.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  input bit offered.
in_bit  input  1  data bit.
in_last  input  1  marks the last data bit of a frame.
in_ready  output  1  encoder accepts in_bit this cycle.
noise_en  input  1  enables error injection; sampled per symbol.
out_valid  output  1  out_bits holds a symbol.
out_ready  input  1  downstream accepts the symbol.
out_bits  output  N  coded symbol, after noise.
out_last  output  1  marks the final tail symbol of a frame.
out_err  output  1  this symbol carries an injected flip.

Function
REQ-006 SHALL hold a K-1 bit shift register SR, where SR[0] is the most recent accepted bit.
REQ-007 SHALL compute the clean symbol as c[i] = XOR over j of (G[i][j] & T[j]), where T = {SR, x} and x is the bit being encoded.
REQ-008 SHALL implement the FSM states IDLE, DATA, FLUSH, with these transitions:
- IDLE -> DATA on the first in_valid & in_ready.
- DATA -> FLUSH when a bit with in_last is accepted.
- FLUSH emits K-1 zero-input tail symbols, then goes to IDLE and clears SR.
REQ-009 SHALL drive in_ready = 1 only in IDLE/DATA, and only when the output register is empty or is being drained this cycle (out_ready & out_valid).
REQ-010 SHALL have a latency of exactly one cycle: a bit accepted at edge t appears on out_bits after edge t, with out_valid=1.
REQ-011 SHALL keep out_bits, out_last and out_err stable while out_valid & !out_ready.
REQ-012 SHALL support full throughput: with out_ready held at 1, it accepts one bit per cycle with no bubbles.
REQ-013 SHALL, in FLUSH, produce tail symbols only when the output register is free; in_ready=0 throughout FLUSH.
REQ-014 SHALL assert out_last only on the (K-1)-th tail symbol.
REQ-015 SHALL count emitted symbols in sym_cnt, which wraps at NOISE_PERIOD-1 -> 0.
REQ-016 SHALL, when noise_en=1 at the cycle a symbol is loaded and sym_cnt==NOISE_PERIOD-1:
- invert bit ch of the symbol, where ch is a 2-bit channel pointer;
- set out_err=1;
- advance ch modulo N.
REQ-017 SHALL increment sym_cnt on every loaded symbol regardless of noise_en; ch SHALL change only on an injection.
REQ-018 SHALL NOT stall the encoder for an in_valid that arrives during FLUSH; the bit is held off by in_ready=0.
REQ-019 SHALL NOT clear SR for an in_last on a single-bit frame; it SHALL follow REQ-008, giving 1 data symbol plus K-1 tail symbols.

Reset
REQ-020 SHALL, on reset assertion, immediately set: FSM=IDLE, SR=0, sym_cnt=0, ch=0, out_valid=0, out_bits=0, out_last=0, out_err=0, in_ready=0.
REQ-021 SHALL, on reset mid-frame, drop the frame with no tail symbols; in_ready SHALL return to 1 on the first clock after deassertion.

Structure
REQ-022 SHALL place the FSM state enum, the maximum K/N limits and the default generator constants in the shared package cc_pkg.
REQ-023 SHALL place the noise injector (sym_cnt, ch, flip mask) in one sub-module, cc_noise_inj; the encoder datapath and FSM SHALL stay in the top module.

Verification
REQ-024 SHALL cover: K=3, N=2, G={5,7}, noise_en=0, bits 1,0,1,1(last), out_ready=1 -> (out_bits[1],out_bits[0]) = 11,01,00,10, then tail 10,11 with out_last on the last symbol.
REQ-025 SHALL cover: the same stimulus with out_ready toggling 1,0,1,0 -> identical symbol sequence, no drop or duplicate, and outputs stable while stalled.
REQ-026 SHALL cover: noise_en=1, NOISE_PERIOD=4, 12 zero bits -> symbols 4, 8 and 12 flip bits 0, 1, 0 respectively, with out_err=1 only on those symbols.
REQ-027 SHALL cover: reset asserted after the 2nd bit -> out_valid=0 within the same cycle; the next frame starting with bit 1 yields symbol 11.
REQ-028 SHALL cover: a single-bit frame (bit 1, last), K=5 -> 1 data symbol plus 4 tail symbols, with in_ready=0 for those 4 cycles.
REQ-029 SHALL cover: K=7, N=3, G={133,171,165} octal, 64 random bits -> the output matches the reference-model XOR equations bit-exactly.
